// File: rtl/oflow_dma_set_loader.sv
// oflow_dma_set_loader: packs DMA bbox stream into PE_NUM-wide ping-pong sets for the core (optional OFLOW_SET_LOADER_STALL_CNT_EN adds dma_stall_cycles)
module oflow_dma_set_loader #(
  parameter int PE_NUM = 24,
  parameter int BBOX_VECTOR_SIZE = 128,
  parameter int NUM_OF_BBOX_IN_FRAME_WIDTH = 10
) (
  input  logic clk,
  input  logic reset_N,
  input  logic start_frame,
  input  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0] num_of_bbox_in_frame,
  input  logic [BBOX_VECTOR_SIZE-1:0] bbox_in,
  input  logic bbox_valid,
  output logic bbox_ready,
  input  logic ready_new_set,
  output logic [PE_NUM-1:0][BBOX_VECTOR_SIZE-1:0] set_of_bboxes_from_dma,
  output logic [PE_NUM-1:0] set_valid_mask,
  output logic new_set_from_dma,
  output logic loader_busy,
  output logic frame_done
`ifdef OFLOW_SET_LOADER_STALL_CNT_EN
  , output logic [15:0] dma_stall_cycles
`endif
);
  localparam int SW = $clog2(PE_NUM);
  localparam int NW = NUM_OF_BBOX_IN_FRAME_WIDTH;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state, state_d;
  logic [1:0][PE_NUM-1:0][BBOX_VECTOR_SIZE-1:0] bank;
  logic [1:0][PE_NUM-1:0] mask;
  logic [1:0] full;
  logic wr_bank, rd_bank;
  logic [SW-1:0] slot;
  logic [NW-1:0] remaining;
  logic start_ok, accept, close_set, issue, drained, done_d, busy_d;
  always_comb begin
    start_ok = state == IDLE && start_frame;
    bbox_ready = state == FILL && !full[wr_bank] && remaining != '0;
    accept = bbox_valid && bbox_ready;
    close_set = accept && (slot == SW'(PE_NUM - 1) || remaining == NW'(1));
    issue = full[rd_bank] && ready_new_set;
    drained = state == DRAIN && full == 2'b00;
    state_d = start_ok ? (num_of_bbox_in_frame != '0 ? FILL : IDLE) :
              (accept && remaining == NW'(1)) ? DRAIN :
              drained ? IDLE : state;
    done_d = (start_ok && num_of_bbox_in_frame == '0) || drained;
    busy_d = start_ok ? num_of_bbox_in_frame != '0 : drained ? 1'b0 : loader_busy;
  end
  always_ff @(posedge clk or negedge reset_N)
    if (!reset_N) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      bank <= '0;
      mask <= '0;
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      slot <= '0;
      remaining <= '0;
      set_of_bboxes_from_dma <= '0;
      set_valid_mask <= '0;
      new_set_from_dma <= 1'b0;
      loader_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (start_ok) remaining <= num_of_bbox_in_frame;
      if (accept) begin
        bank[wr_bank][slot] <= bbox_in;
        mask[wr_bank][slot] <= 1'b1;
        remaining <= remaining - NW'(1);
        slot <= close_set ? '0 : slot + SW'(1);
      end
      if (close_set) begin
        full[wr_bank] <= 1'b1;
        wr_bank <= ~wr_bank;
      end
      if (issue) begin
        for (int i = 0; i < PE_NUM; i++)
          set_of_bboxes_from_dma[i] <= mask[rd_bank][i] ? bank[rd_bank][i] : '0;
        set_valid_mask <= mask[rd_bank];
        mask[rd_bank] <= '0;
        full[rd_bank] <= 1'b0;
        rd_bank <= ~rd_bank;
      end
      new_set_from_dma <= issue;
      loader_busy <= busy_d;
      frame_done <= done_d;
    end
  end
`ifdef OFLOW_SET_LOADER_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_N)
    if (!reset_N) dma_stall_cycles <= '0;
    else if (start_ok) dma_stall_cycles <= '0;
    else if (state != IDLE && full != 2'b00 && !ready_new_set && dma_stall_cycles != 16'hFFFF)
      dma_stall_cycles <= dma_stall_cycles + 16'd1;
`endif
endmodule

// File: tb/tb_oflow_dma_set_loader.sv
// tb_oflow_dma_set_loader: directed self-checking bench for oflow_dma_set_loader
module tb_oflow_dma_set_loader;
  logic clk = 1'b0;
  logic reset_N = 1'b0;
  logic start_frame = 1'b0;
  logic [9:0] num = '0;
  logic [127:0] bbox_in = '0;
  logic bbox_valid = 1'b0;
  logic bbox_ready;
  logic ready_new_set = 1'b0;
  logic [23:0][127:0] set_out;
  logic [23:0] set_mask;
  logic new_set, busy, frame_done;
`ifdef OFLOW_SET_LOADER_STALL_CNT_EN
  logic [15:0] stall;
`endif
  oflow_dma_set_loader dut (
    .clk(clk), .reset_N(reset_N), .start_frame(start_frame), .num_of_bbox_in_frame(num),
    .bbox_in(bbox_in), .bbox_valid(bbox_valid), .bbox_ready(bbox_ready),
    .ready_new_set(ready_new_set), .set_of_bboxes_from_dma(set_out),
    .set_valid_mask(set_mask), .new_set_from_dma(new_set), .loader_busy(busy),
    .frame_done(frame_done)
`ifdef OFLOW_SET_LOADER_STALL_CNT_EN
    , .dma_stall_cycles(stall)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errs = 0;
  int cyc = 0, acc = 0, pulses = 0, dones = 0, done_cyc = -1, pulse_cyc = -1, ready_cyc = -1;
  bit ready_seen = 0;
  logic [7:0] tag = '0;
  logic [23:0][127:0] sets [8];
  logic [23:0] masks [8];
  function automatic logic [127:0] mk(input logic [7:0] t, input int i);
    return {104'b0, t, i[15:0]};
  endfunction
  task automatic tick;
    @(negedge clk);
    if (new_set) begin
      if (pulses < 8) begin sets[pulses] = set_out; masks[pulses] = set_mask; end
      pulses++;
      pulse_cyc = cyc;
    end
    if (frame_done) begin dones++; done_cyc = cyc; end
    if (bbox_ready) begin ready_seen = 1; if (ready_cyc < 0) ready_cyc = cyc; end
    if (bbox_valid && bbox_ready) acc++;
    @(posedge clk);
    #1;
    cyc++;
    bbox_in = mk(tag, acc);
  endtask
  task automatic clr;
    pulses = 0; dones = 0; done_cyc = -1; pulse_cyc = -1; ready_cyc = -1; ready_seen = 0;
  endtask
  task automatic start(input logic [9:0] n, input logic [7:0] t);
    clr();
    tag = t; acc = 0; bbox_in = mk(t, 0); num = n;
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
  endtask
  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget && dones == 0; i++) tick();
    checks++; if (dones == 0) begin errs++; $display("FAIL %s_timeout: frame_done not seen in %0d cycles", name, budget); end
    repeat (3) tick();
  endtask
  task automatic test_reset;
    repeat (2) tick();
    checks++; if (bbox_ready !== 1'b0) begin errs++; $display("FAIL rst_ready: got %b want 0", bbox_ready); end
    checks++; if (new_set !== 1'b0) begin errs++; $display("FAIL rst_new_set: got %b want 0", new_set); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", frame_done); end
    checks++; if (set_mask !== 24'h0) begin errs++; $display("FAIL rst_mask: got %h want 0", set_mask); end
    checks++; if (set_out !== '0) begin errs++; $display("FAIL rst_set: got nonzero want 0"); end
    reset_N = 1'b1;
    tick();
  endtask
  task automatic test_partial;
    logic [23:0][127:0] exp;
    ready_new_set = 1'b1; bbox_valid = 1'b1;
    start(10'd50, 8'h11);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL p_busy: got %b want 1", busy); end
    wait_done(200, "partial");
    bbox_valid = 1'b0;
    for (int i = 0; i < 24; i++) exp[i] = mk(8'h11, 24 + i);
    checks++; if (acc != 50) begin errs++; $display("FAIL p_accepts: got %0d want 50", acc); end
    checks++; if (pulses != 3) begin errs++; $display("FAIL p_pulses: got %0d want 3", pulses); end
    checks++; if (masks[0] !== 24'hFFFFFF) begin errs++; $display("FAIL p_mask0: got %h want ffffff", masks[0]); end
    checks++; if (masks[1] !== 24'hFFFFFF) begin errs++; $display("FAIL p_mask1: got %h want ffffff", masks[1]); end
    checks++; if (masks[2] !== 24'h000003) begin errs++; $display("FAIL p_mask2: got %h want 000003", masks[2]); end
    checks++; if (sets[1] !== exp) begin errs++; $display("FAIL p_set1: slot0 got %h want %h", sets[1][0], exp[0]); end
    checks++; if (sets[2][0] !== mk(8'h11, 48)) begin errs++; $display("FAIL p_set2_s0: got %h want %h", sets[2][0], mk(8'h11, 48)); end
    checks++; if (sets[2][1] !== mk(8'h11, 49)) begin errs++; $display("FAIL p_set2_s1: got %h want %h", sets[2][1], mk(8'h11, 49)); end
    checks++; if (sets[2][23:2] !== '0) begin errs++; $display("FAIL p_set2_pad: slot2 got %h want 0", sets[2][2]); end
    checks++; if (done_cyc - pulse_cyc != 1) begin errs++; $display("FAIL p_done_lat: got %0d want 1", done_cyc - pulse_cyc); end
    checks++; if (dones != 1) begin errs++; $display("FAIL p_done_cnt: got %0d want 1", dones); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL p_busy_end: got %b want 0", busy); end
  endtask
  task automatic test_stall;
    ready_new_set = 1'b0; bbox_valid = 1'b1;
    start(10'd24, 8'h22);
    for (int i = 0; i < 40 && acc < 24; i++) tick();
    ready_seen = 0;
    repeat (100) tick();
    checks++; if (acc != 24) begin errs++; $display("FAIL s_accepts: got %0d want 24", acc); end
    checks++; if (pulses != 0) begin errs++; $display("FAIL s_no_pulse: got %0d want 0", pulses); end
    checks++; if (ready_seen) begin errs++; $display("FAIL s_ready_after_last: got 1 want 0"); end
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL s_busy: got %b want 1", busy); end
`ifdef OFLOW_SET_LOADER_STALL_CNT_EN
    checks++; if (stall < 16'd99 || stall > 16'd101) begin errs++; $display("FAIL s_stall_cnt: got %0d want 100", stall); end
`endif
    ready_new_set = 1'b1;
    wait_done(20, "stall");
    bbox_valid = 1'b0;
    checks++; if (pulses != 1) begin errs++; $display("FAIL s_pulses: got %0d want 1", pulses); end
    checks++; if (masks[0] !== 24'hFFFFFF) begin errs++; $display("FAIL s_mask: got %h want ffffff", masks[0]); end
    checks++; if (sets[0][23] !== mk(8'h22, 23)) begin errs++; $display("FAIL s_slot23: got %h want %h", sets[0][23], mk(8'h22, 23)); end
  endtask
  task automatic test_both_full;
    int first_pulse;
    ready_new_set = 1'b0; bbox_valid = 1'b1;
    start(10'd72, 8'h33);
    repeat (80) tick();
    checks++; if (acc != 48) begin errs++; $display("FAIL b_accepts_held: got %0d want 48", acc); end
    checks++; if (bbox_ready !== 1'b0) begin errs++; $display("FAIL b_ready_low: got %b want 0", bbox_ready); end
    ready_cyc = -1;
    ready_new_set = 1'b1;
    first_pulse = -1;
    for (int i = 0; i < 10 && pulses == 0; i++) tick();
    first_pulse = pulse_cyc;
    wait_done(150, "both_full");
    bbox_valid = 1'b0;
    checks++; if (ready_cyc != first_pulse) begin errs++; $display("FAIL b_ready_resume: got cycle %0d want %0d", ready_cyc, first_pulse); end
    checks++; if (acc != 72) begin errs++; $display("FAIL b_accepts: got %0d want 72", acc); end
    checks++; if (pulses != 3) begin errs++; $display("FAIL b_pulses: got %0d want 3", pulses); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (sets[k][0] !== mk(8'h33, 24 * k) || sets[k][23] !== mk(8'h33, 24 * k + 23))
        begin errs++; $display("FAIL b_order%0d: got %h want %h", k, sets[k][0], mk(8'h33, 24 * k)); end
    end
  endtask
  task automatic test_zero;
    int cs;
    ready_new_set = 1'b1; bbox_valid = 1'b1;
    cs = cyc;
    start(10'd0, 8'h44);
    repeat (5) tick();
    bbox_valid = 1'b0;
    checks++; if (done_cyc != cs + 1) begin errs++; $display("FAIL z_done_cycle: got %0d want %0d", done_cyc, cs + 1); end
    checks++; if (dones != 1) begin errs++; $display("FAIL z_done_cnt: got %0d want 1", dones); end
    checks++; if (pulses != 0) begin errs++; $display("FAIL z_pulses: got %0d want 0", pulses); end
    checks++; if (ready_seen) begin errs++; $display("FAIL z_ready: got 1 want 0"); end
  endtask
  task automatic test_restart_ignored;
    ready_new_set = 1'b1; bbox_valid = 1'b1;
    start(10'd30, 8'h55);
    repeat (8) tick();
    num = 10'd5; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    wait_done(100, "restart");
    bbox_valid = 1'b0;
    checks++; if (acc != 30) begin errs++; $display("FAIL r_accepts: got %0d want 30", acc); end
    checks++; if (pulses != 2) begin errs++; $display("FAIL r_pulses: got %0d want 2", pulses); end
    checks++; if (masks[1] !== 24'h00003F) begin errs++; $display("FAIL r_mask1: got %h want 00003f", masks[1]); end
    checks++; if (dones != 1) begin errs++; $display("FAIL r_done_cnt: got %0d want 1", dones); end
  endtask
  task automatic test_reset_mid;
    ready_new_set = 1'b1; bbox_valid = 1'b1;
    start(10'd30, 8'h66);
    for (int i = 0; i < 30 && acc < 10; i++) tick();
    reset_N = 1'b0;
    #1;
    checks++; if (bbox_ready !== 1'b0 || busy !== 1'b0 || new_set !== 1'b0) begin errs++; $display("FAIL m_ctrl_zero: got ready=%b busy=%b new=%b want 0", bbox_ready, busy, new_set); end
    checks++; if (set_mask !== 24'h0 || set_out !== '0) begin errs++; $display("FAIL m_out_zero: got mask %h want 0", set_mask); end
    repeat (3) tick();
    reset_N = 1'b1;
    repeat (3) tick();
    checks++; if (dones != 0 || pulses != 0) begin errs++; $display("FAIL m_no_done: got dones=%0d pulses=%0d want 0", dones, pulses); end
    start(10'd24, 8'h77);
    wait_done(60, "post_reset");
    bbox_valid = 1'b0;
    checks++; if (pulses != 1 || masks[0] !== 24'hFFFFFF) begin errs++; $display("FAIL m_new_frame: got pulses=%0d mask=%h want 1/ffffff", pulses, masks[0]); end
    checks++; if (sets[0][0] !== mk(8'h77, 0)) begin errs++; $display("FAIL m_new_slot0: got %h want %h", sets[0][0], mk(8'h77, 0)); end
  endtask
  initial begin
    #1;
    test_reset();
    test_partial();
    test_stall();
    test_both_full();
    test_zero();
    test_restart_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
